// File: rtl/key_onehot_scanner.sv
// Key scanner: synchronises, debounces and locks onto one of 8 raw keys, giving a one-hot output.
// Optional macro AUTO_REPEAT_EN adds press_pulse auto-repeat while a key is held.
module key_onehot_scanner #(
  parameter int DB_CNT     = 16,
  parameter int RPT_DELAY  = 1000,
  parameter int RPT_PERIOD = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_raw,
  output logic [7:0] onehot,
  output logic       key_valid,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    WAIT_UP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [7:0]        s1, s2, db;
  logic [7:0][15:0]  cnt;
  logic [7:0]        onehot_next;
  logic              key_valid_next, press_next, release_next, multi_next;
`ifdef AUTO_REPEAT_EN
  logic [15:0]       rpt_cnt, rpt_next;
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // Two-flop synchroniser and per-key debounce counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 8'd0;
      s2  <= 8'd0;
      db  <= 8'd0;
      cnt <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= 16'd0;
        end else if (cnt[i] == 16'(DB_CNT - 1)) begin
          db[i]  <= s2[i];
          cnt[i] <= 16'd0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_next     = state;
    onehot_next    = onehot;
    key_valid_next = key_valid;
    press_next     = 1'b0;
    release_next   = 1'b0;
    multi_next     = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_next       = 16'd0;
`endif
    case (state)
      IDLE: begin
        if (db != 8'd0) begin
          onehot_next    = lowest_bit(db);
          key_valid_next = 1'b1;
          press_next     = 1'b1;
          multi_next     = (popcount8(db) > 4'd1);
          state_next     = HELD;
`ifdef AUTO_REPEAT_EN
          rpt_next       = 16'(RPT_DELAY - 1);
`endif
        end else begin
          state_next = IDLE;
        end
      end
      HELD: begin
        if ((db & onehot) == 8'd0) begin
          onehot_next    = 8'd0;
          key_valid_next = 1'b0;
          release_next   = 1'b1;
          // Selected bit is already clear, so db==0 means every other key is up too.
          state_next     = (db == 8'd0) ? IDLE : WAIT_UP;
        end else begin
          state_next = HELD;
`ifdef AUTO_REPEAT_EN
          if (rpt_cnt == 16'd0) begin
            press_next = 1'b1;
            rpt_next   = 16'(RPT_PERIOD - 1);
          end else begin
            rpt_next = rpt_cnt - 16'd1;
          end
`endif
        end
      end
      WAIT_UP: begin
        if (db == 8'd0) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_UP;
        end
      end
      default: begin
        state_next     = IDLE;
        onehot_next    = 8'd0;
        key_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      onehot        <= 8'd0;
      key_valid     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      multi_err     <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt       <= 16'd0;
`endif
    end else begin
      state         <= state_next;
      onehot        <= onehot_next;
      key_valid     <= key_valid_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      multi_err     <= multi_next;
`ifdef AUTO_REPEAT_EN
      rpt_cnt       <= rpt_next;
`endif
    end
  end

endmodule

// File: tb/tb_key_onehot_scanner.sv
// Directed self-checking bench for key_onehot_scanner (DB_CNT=4, RPT_DELAY=10, RPT_PERIOD=4).
module tb_key_onehot_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_raw;
  logic [7:0] onehot;
  logic       key_valid, press_pulse, release_pulse, multi_err;
  int         n_assert;
  int         n_fail;

  key_onehot_scanner #(.DB_CNT(4), .RPT_DELAY(10), .RPT_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .onehot(onehot),
    .key_valid(key_valid), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .multi_err(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    key_raw  = 8'h00;
    #1;
    chk8("reset_onehot", onehot, 8'h00);
    chk1("reset_valid", key_valid, 1'b0);
    step(3);
    chk1("reset_press", press_pulse, 1'b0);
    chk1("reset_release", release_pulse, 1'b0);
    chk1("reset_multi", multi_err, 1'b0);
    rst_n = 1'b1;
    step(3);

    // Clean press and release of key 5: output appears on the 7th edge after driving.
    key_raw = 8'h20;
    step(6);
    chk8("clean_early", onehot, 8'h00);
    step(1);
    chk8("clean_onehot", onehot, 8'h20);
    chk1("clean_valid", key_valid, 1'b1);
    chk1("clean_press", press_pulse, 1'b1);
    chk1("clean_multi", multi_err, 1'b0);
    step(1);
    chk1("clean_press_end", press_pulse, 1'b0);
    chk8("clean_hold", onehot, 8'h20);
    key_raw = 8'h00;
    step(6);
    chk8("clean_rel_early", onehot, 8'h20);
    step(1);
    chk8("clean_rel_onehot", onehot, 8'h00);
    chk1("clean_rel_valid", key_valid, 1'b0);
    chk1("clean_rel_pulse", release_pulse, 1'b1);
    step(1);
    chk1("clean_rel_end", release_pulse, 1'b0);

    // Bounce on key 3: 2-cycle levels never pass a 4-cycle debounce.
    for (int p = 0; p < 10; p++) begin
      key_raw = (p % 2 == 0) ? 8'h08 : 8'h00;
      step(2);
      chk8("bounce_quiet", onehot, 8'h00);
      chk1("bounce_nopress", press_pulse, 1'b0);
    end
    key_raw = 8'h08;
    step(6);
    chk8("bounce_early", onehot, 8'h00);
    step(1);
    chk8("bounce_onehot", onehot, 8'h08);
    chk1("bounce_press", press_pulse, 1'b1);
    key_raw = 8'h00;
    step(7);
    chk8("bounce_rel", onehot, 8'h00);
    chk1("bounce_rel_pulse", release_pulse, 1'b1);
    step(2);

    // Simultaneous keys 7 and 2: lowest wins, multi_err flags it.
    key_raw = 8'h84;
    step(7);
    chk8("multi_onehot", onehot, 8'h04);
    chk1("multi_err", multi_err, 1'b1);
    chk1("multi_press", press_pulse, 1'b1);
    step(1);
    chk1("multi_err_end", multi_err, 1'b0);
    key_raw = 8'h80;
    step(7);
    chk8("multi_rel_onehot", onehot, 8'h00);
    chk1("multi_rel_valid", key_valid, 1'b0);
    chk1("multi_rel_pulse", release_pulse, 1'b1);
    key_raw = 8'h00;
    for (int c = 0; c < 12; c++) begin
      step(1);
      chk8("waitup_onehot", onehot, 8'h00);
      chk1("waitup_nopress", press_pulse, 1'b0);
      chk1("waitup_norel", release_pulse, 1'b0);
    end
    key_raw = 8'h01;
    step(7);
    chk8("after_wait_onehot", onehot, 8'h01);
    chk1("after_wait_press", press_pulse, 1'b1);
    chk1("after_wait_multi", multi_err, 1'b0);
    key_raw = 8'h00;
    step(8);
    chk8("after_wait_rel", onehot, 8'h00);

    // Held key 1 ignores a later key 6.
    key_raw = 8'h02;
    step(7);
    chk8("hold_onehot", onehot, 8'h02);
    chk1("hold_press", press_pulse, 1'b1);
    step(2);
    key_raw = 8'h42;
    for (int c = 0; c < 8; c++) begin
      step(1);
      chk8("hold_ignore_onehot", onehot, 8'h02);
      chk1("hold_ignore_press", press_pulse, 1'b0);
    end
    key_raw = 8'h00;
    step(7);
    chk8("hold_rel_onehot", onehot, 8'h00);
    chk1("hold_rel_pulse", release_pulse, 1'b1);
    step(4);

    // Reset mid-press with key 4 held, then re-acceptance.
    key_raw = 8'h10;
    step(7);
    chk8("rst_pre_onehot", onehot, 8'h10);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("rst_mid_onehot", onehot, 8'h00);
    chk1("rst_mid_valid", key_valid, 1'b0);
    chk1("rst_mid_press", press_pulse, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk8("rst_re_early", onehot, 8'h00);
    step(2);
    chk8("rst_re_onehot", onehot, 8'h10);
    chk1("rst_re_press", press_pulse, 1'b1);

    // Auto-repeat (enabled build) or single pulse (default build) while key 4 stays held.
    for (int m = 1; m <= 20; m++) begin
      step(1);
`ifdef AUTO_REPEAT_EN
      chk1("repeat_pulse", press_pulse, (m == 10 || m == 14 || m == 18) ? 1'b1 : 1'b0);
`else
      chk1("norepeat_pulse", press_pulse, 1'b0);
`endif
      chk8("repeat_onehot", onehot, 8'h10);
    end
    key_raw = 8'h00;
    step(7);
    chk8("final_rel", onehot, 8'h00);
    chk1("final_rel_pulse", release_pulse, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
